// File: rtl/ram_sp_burst_master_pkg.sv
// Shared types for the single-port RAM burst master: FSM states, command bundle
// and the address-window check used when RAM_BURST_BOUND_CHK_EN is defined.
package ram_burst_pkg;

    localparam int BURST_DATA_W    = 8;
    localparam int BURST_ADDR_W    = 8;
    localparam int BURST_LEN_W     = BURST_ADDR_W;
    localparam int BURST_RAM_DEPTH = 1 << BURST_ADDR_W;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} burst_state_t;

    typedef struct packed {
        logic                    write;
        logic [BURST_ADDR_W-1:0] addr;
        logic [BURST_LEN_W-1:0]  len;
    } burst_cmd_t;

    // One extra bit so a burst running past the top of the RAM is visible instead of wrapping.
    function automatic logic burst_out_of_bounds(input logic [BURST_ADDR_W-1:0] addr,
                                                 input logic [BURST_LEN_W-1:0]  len);
        logic [BURST_LEN_W:0] last_addr;
        last_addr = (BURST_LEN_W+1)'(addr) + (BURST_LEN_W+1)'(len);
        return last_addr > (BURST_LEN_W+1)'(BURST_RAM_DEPTH - 1);
    endfunction

endpackage

// File: rtl/ram_sp_burst_master_if.sv
// Command, write-stream, read-stream, status and RAM-side signals of the burst master.
// The master modport is the burst engine's view; slave is the surrounding system and RAM.
interface ram_sp_burst_master_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  done;
    logic                  err;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] ram_address;
    logic [DATA_WIDTH-1:0] ram_data_in;
    logic                  ram_write_en;
    logic                  ram_chip_sel;
    logic [DATA_WIDTH-1:0] ram_data_out;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, ram_data_out,
        output cmd_ready, wr_ready, rd_valid, rd_data, done, err, busy,
               ram_address, ram_data_in, ram_write_en, ram_chip_sel
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, ram_data_out,
        input  cmd_ready, wr_ready, rd_valid, rd_data, done, err, busy,
               ram_address, ram_data_in, ram_write_en, ram_chip_sel
    );
endinterface

// File: rtl/ram_sp_burst_master_addr_gen.sv
// Burst address / remaining-beat counters. load seeds them from a command, step advances
// one beat (address wraps naturally), last flags the final beat of the burst.
module ram_burst_addr_gen #(
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [LEN_WIDTH-1:0]  load_len,
    input  logic                  step,
    output logic [ADDR_WIDTH-1:0] cur_addr,
    output logic                  last
);
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;

    always_comb begin
        cur_addr_d = cur_addr_q;
        rem_d      = rem_q;
        if (load) begin
            cur_addr_d = load_addr;
            rem_d      = load_len;
        end else if (step) begin
            cur_addr_d = cur_addr_q + 1'b1;
            rem_d      = rem_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr_q <= '0;
            rem_q      <= '0;
        end else begin
            cur_addr_q <= cur_addr_d;
            rem_q      <= rem_d;
        end
    end

    assign cur_addr = cur_addr_q;
    assign last     = (rem_q == '0);
endmodule

// File: rtl/ram_sp_burst_master.sv
// Burst initiator for a single-port synchronous RAM: streams write data into, or read data out of,
// consecutive words at full rate. Define RAM_BURST_BOUND_CHK_EN to reject bursts past the last word.
module ram_sp_burst_master
    import ram_burst_pkg::*;
#(
    parameter int DATA_WIDTH = BURST_DATA_W,
    parameter int ADDR_WIDTH = BURST_ADDR_W,
    parameter int LEN_WIDTH  = BURST_LEN_W
) (
    input logic                   clk,
    input logic                   rst,
    ram_sp_burst_master_if.master bus
);
    burst_state_t          state_q, state_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH-1:0] addr_hold_q, addr_hold_d;
    logic [DATA_WIDTH-1:0] data_hold_q, data_hold_d;
    logic                  load, step, last;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic                  chip_sel, write_en, wr_ready;
    logic [ADDR_WIDTH-1:0] ram_address;
    logic [DATA_WIDTH-1:0] ram_data_in;
    burst_cmd_t            cmd;
    logic                  reject;

    assign cmd = '{write: bus.cmd_write, addr: bus.cmd_addr, len: bus.cmd_len};

`ifdef RAM_BURST_BOUND_CHK_EN
    logic err_q, err_d;
    assign reject  = burst_out_of_bounds(cmd.addr, cmd.len);
    assign bus.err = err_q;
`else
    assign reject  = 1'b0;
    assign bus.err = 1'b0;
`endif

    ram_burst_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .LEN_WIDTH (LEN_WIDTH)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_addr(cmd.addr),
        .load_len (cmd.len),
        .step     (step),
        .cur_addr (cur_addr),
        .last     (last)
    );

    // A read is only issued when the presented word is free to be replaced, so the RAM's
    // data_out (and therefore rd_data) holds under backpressure without an extra buffer.
    always_comb begin
        state_d     = state_q;
        rd_valid_d  = rd_valid_q;
        done_d      = 1'b0;
        load        = 1'b0;
        step        = 1'b0;
        chip_sel    = 1'b0;
        write_en    = 1'b0;
        wr_ready    = 1'b0;
        ram_address = addr_hold_q;
        ram_data_in = data_hold_q;
`ifdef RAM_BURST_BOUND_CHK_EN
        err_d       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (reject) begin
                        done_d = 1'b1;
`ifdef RAM_BURST_BOUND_CHK_EN
                        err_d  = 1'b1;
`endif
                    end else begin
                        load    = 1'b1;
                        state_d = cmd.write ? WRITE : READ;
                    end
                end
            end
            WRITE: begin
                wr_ready = 1'b1;
                if (bus.wr_valid) begin
                    chip_sel    = 1'b1;
                    write_en    = 1'b1;
                    ram_address = cur_addr;
                    ram_data_in = bus.wr_data;
                    step        = 1'b1;
                    if (last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            READ: begin
                if (bus.rd_ready) begin
                    rd_valid_d = 1'b0;
                end
                if (!rd_valid_q || bus.rd_ready) begin
                    chip_sel    = 1'b1;
                    ram_address = cur_addr;
                    step        = 1'b1;
                    rd_valid_d  = 1'b1;
                    if (last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (rd_valid_q && bus.rd_ready) begin
                    rd_valid_d = 1'b0;
                    state_d    = IDLE;
                    done_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Reset aborts immediately: no RAM access even in the cycle reset is sampled.
        if (rst) begin
            chip_sel    = 1'b0;
            write_en    = 1'b0;
            ram_address = addr_hold_q;
            ram_data_in = data_hold_q;
        end
        addr_hold_d = ram_address;
        data_hold_d = ram_data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            addr_hold_q <= '0;
            data_hold_q <= '0;
`ifdef RAM_BURST_BOUND_CHK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rd_valid_q  <= rd_valid_d;
            done_q      <= done_d;
            addr_hold_q <= addr_hold_d;
            data_hold_q <= data_hold_d;
`ifdef RAM_BURST_BOUND_CHK_EN
            err_q       <= err_d;
`endif
        end
    end

    assign bus.cmd_ready    = (state_q == IDLE);
    assign bus.busy         = (state_q != IDLE);
    assign bus.wr_ready     = wr_ready;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_data      = bus.ram_data_out;
    assign bus.done         = done_q;
    assign bus.ram_address  = ram_address;
    assign bus.ram_data_in  = ram_data_in;
    assign bus.ram_write_en = write_en;
    assign bus.ram_chip_sel = chip_sel;
endmodule

// File: tb/tb_ram_sp_burst_master.sv
// Bench for ram_sp_burst_master: drives bursts through a behavioural single-port RAM and compares
// every beat against an expected-memory array maintained from the burst rules.
module tb_ram_sp_burst_master;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] mem     [256];
    logic [7:0] exp_mem [256];
    int wr_pulses = 0;
    int rd_issues = 0;

    ram_sp_burst_master_if bus ();

    ram_sp_burst_master dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM: one-cycle read latency, data_out holds between reads.
    always @(posedge clk) begin
        if (bus.ram_chip_sel) begin
            if (bus.ram_write_en) begin
                mem[bus.ram_address] <= bus.ram_data_in;
                wr_pulses <= wr_pulses + 1;
            end else begin
                bus.ram_data_out <= mem[bus.ram_address];
                rd_issues <= rd_issues + 1;
            end
        end
    end

    task automatic send_cmd(input logic w, input logic [7:0] a, input logic [7:0] l);
        int t = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        while (bus.cmd_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (bus.cmd_ready !== 1'b1) $display("[TB] FAIL cmd_accept: got %b expected 1", bus.cmd_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic write_burst(input logic [7:0] a, input logic [7:0] l, input bit seq_data,
                               input int gap_at, input int gap_len);
        int beat = 0;
        int cyc = 0;
        int gap_left = gap_len;
        int w0;
        logic [7:0] ea;
        send_cmd(1'b1, a, l);
        w0 = wr_pulses;
        while (beat <= int'(l) && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (beat == gap_at && gap_left > 0) begin
                bus.wr_valid = 1'b0;
                gap_left--;
            end else begin
                bus.wr_valid = 1'b1;
                bus.wr_data  = seq_data ? 8'(8'hA0 + beat) : 8'($urandom);
            end
            #1;
            ea = 8'(int'(a) + beat);
            n_checks++;
            if (bus.wr_valid) begin
                if ({bus.wr_ready, bus.ram_chip_sel, bus.ram_write_en, bus.ram_address, bus.ram_data_in}
                    !== {3'b111, ea, bus.wr_data})
                    $display("[TB] FAIL wr_beat: got rdy/cs/we/addr/data %b%b%b/%h/%h expected 111/%h/%h",
                             bus.wr_ready, bus.ram_chip_sel, bus.ram_write_en, bus.ram_address,
                             bus.ram_data_in, ea, bus.wr_data);
                else n_pass++;
                exp_mem[ea] = bus.wr_data;
                beat++;
            end else begin
                if (bus.ram_chip_sel !== 1'b0) $display("[TB] FAIL wr_gap_idle: got cs %b expected 0", bus.ram_chip_sel);
                else n_pass++;
            end
        end
        n_checks++;
        if (beat <= int'(l)) $display("[TB] FAIL wr_timeout: got %0d beats expected %0d", beat, int'(l) + 1);
        else n_pass++;
        @(negedge clk);
        bus.wr_valid = 1'b0;
        #1;
        n_checks++;
        if ({bus.done, bus.err, bus.busy} !== 3'b100)
            $display("[TB] FAIL wr_done: got done/err/busy %b%b%b expected 100", bus.done, bus.err, bus.busy);
        else n_pass++;
        n_checks++;
        if (wr_pulses - w0 != int'(l) + 1)
            $display("[TB] FAIL wr_count: got %0d expected %0d", wr_pulses - w0, int'(l) + 1);
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.done !== 1'b0) $display("[TB] FAIL wr_done_pulse: got %b expected 0", bus.done);
        else n_pass++;
    endtask

    // mode 0: always ready, 1: ready toggling 1010..., 2: random ready
    task automatic read_burst(input logic [7:0] a, input logic [7:0] l, input int mode);
        int got = 0;
        int cyc = 0;
        int r0;
        bit stalled = 1'b0;
        logic [7:0] held = '0;
        logic [7:0] ea;
        send_cmd(1'b0, a, l);
        r0 = rd_issues;
        while (got <= int'(l) && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            bus.rd_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
            #1;
            if (cyc <= 2) begin
                n_checks++;
                if (bus.rd_valid !== (cyc == 2))
                    $display("[TB] FAIL rd_latency: cycle %0d got %b expected %b", cyc, bus.rd_valid, cyc == 2);
                else n_pass++;
            end
            if (stalled) begin
                n_checks++;
                if ({bus.rd_valid, bus.rd_data} !== {1'b1, held})
                    $display("[TB] FAIL rd_hold: got %b/%h expected 1/%h", bus.rd_valid, bus.rd_data, held);
                else n_pass++;
            end
            if (bus.rd_valid && !bus.rd_ready) begin
                n_checks++;
                if (bus.ram_chip_sel !== 1'b0) $display("[TB] FAIL rd_stall_issue: got cs %b expected 0", bus.ram_chip_sel);
                else n_pass++;
            end
            if (bus.rd_valid && bus.rd_ready) begin
                ea = 8'(int'(a) + got);
                n_checks++;
                if (bus.rd_data !== exp_mem[ea])
                    $display("[TB] FAIL rd_data: word %0d got %h expected %h", got, bus.rd_data, exp_mem[ea]);
                else n_pass++;
                got++;
            end
            stalled = bus.rd_valid && !bus.rd_ready;
            held    = bus.rd_data;
        end
        n_checks++;
        if (got <= int'(l)) $display("[TB] FAIL rd_timeout: got %0d words expected %0d", got, int'(l) + 1);
        else n_pass++;
        if (mode == 0) begin
            n_checks++;
            if (cyc != int'(l) + 2) $display("[TB] FAIL rd_full_rate: got %0d cycles expected %0d", cyc, int'(l) + 2);
            else n_pass++;
        end
        @(negedge clk);
        bus.rd_ready = 1'b0;
        #1;
        n_checks++;
        if ({bus.done, bus.busy, bus.rd_valid} !== 3'b100)
            $display("[TB] FAIL rd_done: got done/busy/valid %b%b%b expected 100", bus.done, bus.busy, bus.rd_valid);
        else n_pass++;
        n_checks++;
        if (rd_issues - r0 != int'(l) + 1)
            $display("[TB] FAIL rd_issue_count: got %0d expected %0d", rd_issues - r0, int'(l) + 1);
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.done !== 1'b0) $display("[TB] FAIL rd_done_pulse: got %b expected 0", bus.done);
        else n_pass++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({bus.rd_valid, bus.done, bus.err, bus.busy, bus.ram_chip_sel, bus.ram_write_en} !== 6'b0)
            $display("[TB] FAIL reset_flags: got %b expected 000000",
                     {bus.rd_valid, bus.done, bus.err, bus.busy, bus.ram_chip_sel, bus.ram_write_en});
        else n_pass++;
        n_checks++;
        if ({bus.ram_address, bus.ram_data_in} !== 16'h0000)
            $display("[TB] FAIL reset_bus: got %h/%h expected 00/00", bus.ram_address, bus.ram_data_in);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if ({bus.cmd_ready, bus.busy} !== 2'b10)
            $display("[TB] FAIL reset_idle: got ready/busy %b%b expected 10", bus.cmd_ready, bus.busy);
        else n_pass++;
    endtask

    task automatic test_write_read;
        write_burst(8'h10, 8'd3, 1'b1, -1, 0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (mem[8'h10 + i] !== 8'(8'hA0 + i))
                $display("[TB] FAIL wr_ram_content: addr %h got %h expected %h", 8'h10 + i, mem[8'h10 + i], 8'(8'hA0 + i));
            else n_pass++;
        end
        read_burst(8'h10, 8'd3, 0);
    endtask

    task automatic test_backpressure;
        write_burst(8'h40, 8'd7, 1'b0, -1, 0);
        read_burst(8'h40, 8'd7, 1);
    endtask

    task automatic test_wrap;
`ifdef RAM_BURST_BOUND_CHK_EN
        int w0;
        w0 = wr_pulses;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h5A;
        send_cmd(1'b1, 8'hFE, 8'd3);
        @(negedge clk);
        #1;
        n_checks++;
        if ({bus.done, bus.err, bus.busy, bus.ram_chip_sel} !== 4'b1100)
            $display("[TB] FAIL bound_reject: got done/err/busy/cs %b%b%b%b expected 1100",
                     bus.done, bus.err, bus.busy, bus.ram_chip_sel);
        else n_pass++;
        bus.wr_valid = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if ({bus.done, bus.err, wr_pulses - w0} !== {2'b00, 32'd0})
            $display("[TB] FAIL bound_untouched: got done/err %b%b writes %0d expected 00 0",
                     bus.done, bus.err, wr_pulses - w0);
        else n_pass++;
`else
        logic [7:0] wa;
        write_burst(8'hFE, 8'd3, 1'b0, -1, 0);
        for (int i = 0; i < 4; i++) begin
            wa = 8'(254 + i);
            n_checks++;
            if (mem[wa] !== exp_mem[wa])
                $display("[TB] FAIL wrap_content: addr %h got %h expected %h", wa, mem[wa], exp_mem[wa]);
            else n_pass++;
        end
        read_burst(8'hFE, 8'd3, 2);
`endif
    endtask

    task automatic test_write_gaps;
        write_burst(8'h80, 8'd5, 1'b0, 2, 3);
        read_burst(8'h80, 8'd5, 0);
    endtask

    task automatic test_reset_mid_read;
        int got = 0;
        int cyc = 0;
        write_burst(8'h60, 8'd5, 1'b0, -1, 0);
        send_cmd(1'b0, 8'h60, 8'd5);
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            bus.rd_ready = 1'b1;
            #1;
            if (bus.rd_valid) begin
                if (got == 2) break;
                got++;
            end
        end
        n_checks++;
        if (got != 2) $display("[TB] FAIL rst_reach_word3: got %0d words expected 2", got);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.ram_chip_sel !== 1'b0) $display("[TB] FAIL rst_no_access: got cs %b expected 0", bus.ram_chip_sel);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({bus.busy, bus.rd_valid, bus.ram_chip_sel, bus.done, bus.cmd_ready} !== 5'b00001)
            $display("[TB] FAIL rst_abort: got busy/valid/cs/done/ready %b expected 00001",
                     {bus.busy, bus.rd_valid, bus.ram_chip_sel, bus.done, bus.cmd_ready});
        else n_pass++;
        bus.rd_ready = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if ({bus.done, bus.ram_chip_sel} !== 2'b00)
            $display("[TB] FAIL rst_no_done: got done/cs %b%b expected 00", bus.done, bus.ram_chip_sel);
        else n_pass++;
    endtask

    task automatic test_single_word;
        read_burst(8'h12, 8'd0, 0);
    endtask

    task automatic test_random;
        logic [7:0] l;
        logic [7:0] a;
        for (int i = 0; i < 4; i++) begin
            l = 8'($urandom_range(0, 12));
            a = 8'($urandom_range(0, 255 - int'(l)));
            write_burst(a, l, 1'b0, $urandom_range(0, int'(l)), $urandom_range(0, 2));
            read_burst(a, l, 2);
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.rd_ready  = 1'b0;
        for (int i = 0; i < 256; i++) exp_mem[i] = '0;
        test_reset;
        test_write_read;
        test_backpressure;
        test_wrap;
        test_write_gaps;
        test_reset_mid_read;
        test_single_word;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
